// File: rtl/result_uart_sender.sv
// Result word UART transmitter: serialises each captured word LSB byte first
// (8N1), with a one-entry pending buffer and a sticky overrun flag.
module result_uart_sender #(
   parameter int unsigned CLK_FREQUENCY = 100_000_000,
   parameter int unsigned BAUD_RATE     = 115_200,
   parameter int unsigned NBYTES        = 4
) (
   input  logic                  CLK100MHZ,
   input  logic                  CPU_RESETN,
   input  logic [8*NBYTES-1:0]   data32,
   input  logic                  flag_ready32,
   output logic                  UART_TX,
   output logic                  flag_sent32,
   output logic                  busy,
   output logic                  overrun
);

   localparam int unsigned BAUD_DIV = CLK_FREQUENCY / BAUD_RATE;
   localparam int unsigned CNT_W    = $clog2(BAUD_DIV + 1);
   localparam int unsigned BYTE_W   = $clog2(NBYTES + 1);
   localparam int unsigned WORD_W   = 8 * NBYTES;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BAUD_DIV - 1);
   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_baud_cnt;
   logic [2:0]          r_bit_idx;
   logic [BYTE_W-1:0]   r_byte_idx;
   logic [WORD_W-1:0]   r_shift;
   logic [WORD_W-1:0]   r_pend_data;
   logic                r_pend_vld;
   logic                r_tx;
   logic                r_sent;
   logic                r_overrun;

   logic                w_bit_end;
   logic                w_in_frame;

   assign w_bit_end  = (r_baud_cnt == CNT_LAST);
   assign w_in_frame = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

   // The current byte always sits in r_shift[7:0]; eight right shifts per byte
   // bring the next byte into place, so no byte-select mux is needed.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_state     <= S_IDLE;
         r_baud_cnt  <= '0;
         r_bit_idx   <= '0;
         r_byte_idx  <= '0;
         r_shift     <= '0;
         // NOTE: the pending data register is reset along with its valid bit so
         // that no X can ever reach the line, even though only r_pend_vld matters.
         r_pend_data <= '0;
         r_pend_vld  <= 1'b0;
         r_tx        <= 1'b1;
         r_sent      <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout; later assignments in this
         // block deliberately override the defaults set here.
         r_sent <= 1'b0;
         if (w_in_frame)
            r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + 1'b1;

         if (w_in_frame && flag_ready32) begin
            if (!r_pend_vld) begin
               r_pend_data <= data32;
               r_pend_vld  <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end

         case (r_state)
            S_IDLE: begin
               r_tx <= 1'b1;
               if (flag_ready32) begin
                  r_shift    <= data32;
                  r_byte_idx <= '0;
                  r_baud_cnt <= '0;
                  r_tx       <= 1'b0;
                  r_state    <= S_START;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_bit_idx <= '0;
                  r_tx      <= r_shift[0];
                  r_state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_shift <= r_shift >> 1;
                  if (r_bit_idx == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_tx      <= r_shift[1];
                  end
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  if (r_byte_idx < BYTE_LAST) begin
                     r_byte_idx <= r_byte_idx + 1'b1;
                     r_tx       <= 1'b0;
                     r_state    <= S_START;
                  end else begin
                     r_sent  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               r_byte_idx <= '0;
               r_baud_cnt <= '0;
               if (r_pend_vld) begin
                  // Pending slot is drained now, so a same-cycle request refills it.
                  r_shift    <= r_pend_data;
                  r_pend_vld <= flag_ready32;
                  if (flag_ready32)
                     r_pend_data <= data32;
                  r_tx    <= 1'b0;
                  r_state <= S_START;
               end else if (flag_ready32) begin
                  r_shift <= data32;
                  r_tx    <= 1'b0;
                  r_state <= S_START;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign UART_TX     = r_tx;
   assign flag_sent32 = r_sent;
   assign overrun     = r_overrun;
   assign busy        = (r_state != S_IDLE) || r_pend_vld;

endmodule

// File: tb/tb_result_uart_sender.sv
// Directed bench for result_uart_sender at BAUD_DIV=10 (400 cycles per word);
// the line is logged every cycle and decoded afterwards.
module tb_result_uart_sender;

   logic        clk;
   logic        rst_n;
   logic [31:0] data32;
   logic        flag_ready32;
   logic        uart_tx;
   logic        flag_sent32;
   logic        busy;
   logic        overrun;

   int n_checks = 0;
   int n_errors = 0;

   int rel;            // cycle number relative to the last capture edge (cycle 1 follows it)
   logic tx_hist[$];   // tx_hist[k] holds the line during cycle k+1
   int   sent_at[$];   // cycles in which flag_sent32 was high

   result_uart_sender #(
      .CLK_FREQUENCY(1_000_000),
      .BAUD_RATE    (100_000),
      .NBYTES       (4)
   ) dut (
      .CLK100MHZ   (clk),
      .CPU_RESETN  (rst_n),
      .data32      (data32),
      .flag_ready32(flag_ready32),
      .UART_TX     (uart_tx),
      .flag_sent32 (flag_sent32),
      .busy        (busy),
      .overrun     (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      rel++;
      tx_hist.push_back(uart_tx);
      if (flag_sent32) sent_at.push_back(rel);
   endtask

   task automatic run_to(input int n);
      while (rel < n) step();
   endtask

   task automatic clear_log();
      tx_hist.delete();
      sent_at.delete();
      rel = 0;
   endtask

   // Request is captured on the edge that ends the current cycle.
   task automatic send_req(input logic [31:0] d);
      data32       = d;
      flag_ready32 = 1'b1;
      step();
      flag_ready32 = 1'b0;
      data32       = 32'h0;
   endtask

   // Decode one 4-byte frame starting at history index 'start'; every bit must
   // hold its value for exactly 10 cycles, with a low start and a high stop bit.
   task automatic decode(input int start, output logic [31:0] w, output logic ok);
      int   base;
      logic v;
      ok = 1'b1;
      w  = 32'h0;
      for (int b = 0; b < 4; b++) begin
         for (int j = 0; j < 10; j++) begin
            base = start + b * 100 + j * 10;
            if (base + 9 >= tx_hist.size()) begin
               ok = 1'b0;
            end else begin
               v = tx_hist[base];
               for (int k = 1; k < 10; k++)
                  if (tx_hist[base + k] !== v) ok = 1'b0;
               if (j == 0 && v !== 1'b0) ok = 1'b0;
               if (j == 9 && v !== 1'b1) ok = 1'b0;
               if (j >= 1 && j <= 8) w[b * 8 + j - 1] = v;
            end
         end
      end
   endtask

   logic [31:0] word;
   logic        ok;
   logic        idle_ok;

   initial begin
      rst_n        = 1'b0;
      data32       = 32'h0;
      flag_ready32 = 1'b0;
      rel          = 0;

      // 1: reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx", uart_tx, 1);
      check("rst_busy", busy, 0);
      check("rst_sent", flag_sent32, 0);
      check("rst_ovr", overrun, 0);
      rst_n = 1'b1;
      repeat (3) step();
      check("idle_tx", uart_tx, 1);
      check("idle_busy", busy, 0);

      // 2: single word
      clear_log();
      send_req(32'h12345678);
      check("t2_tx_c1", uart_tx, 0);
      check("t2_busy", busy, 1);
      run_to(405);
      decode(0, word, ok);
      check("t2_word", word, 32'h12345678);
      check("t2_frame", ok, 1);
      check("t2_nsent", sent_at.size(), 1);
      check("t2_sent_cyc", sent_at[0], 401);
      check("t2_tx_done", tx_hist[400], 1);
      check("t2_busy_end", busy, 0);

      // 3: back-to-back, second request at edge 50
      clear_log();
      send_req(32'hA5A5A5A5);
      run_to(50);
      send_req(32'h0000FF01);
      run_to(810);
      decode(0, word, ok);
      check("t3_word0", word, 32'hA5A5A5A5);
      check("t3_frame0", ok, 1);
      decode(401, word, ok);
      check("t3_word1", word, 32'h0000FF01);
      check("t3_frame1", ok, 1);
      check("t3_start402", tx_hist[401], 0);
      check("t3_nsent", sent_at.size(), 2);
      check("t3_sent0", sent_at[0], 401);
      check("t3_sent1", sent_at[1], 802);
      check("t3_ovr", overrun, 0);
      check("t3_busy_end", busy, 0);

      // 4: overrun, requests at edges 0, 20 and 40
      clear_log();
      send_req(32'h01020304);
      run_to(20);
      send_req(32'h55AA33CC);
      run_to(40);
      check("t4_ovr_c40", overrun, 0);
      send_req(32'hDEADBEEF);
      check("t4_ovr_c41", overrun, 1);
      run_to(830);
      decode(0, word, ok);
      check("t4_word0", word, 32'h01020304);
      decode(401, word, ok);
      check("t4_word1", word, 32'h55AA33CC);
      check("t4_frame1", ok, 1);
      check("t4_nsent", sent_at.size(), 2);
      idle_ok = 1'b1;
      for (int i = 801; i < tx_hist.size(); i++)
         if (tx_hist[i] !== 1'b1) idle_ok = 1'b0;
      check("t4_line_idle", idle_ok, 1);
      check("t4_ovr_sticky", overrun, 1);
      check("t4_busy_end", busy, 0);

      // overrun clears only through reset
      rst_n = 1'b0;
      #1;
      check("t4_ovr_rst", overrun, 0);
      step();
      rst_n = 1'b1;
      repeat (2) step();

      // 5: request lands exactly in the DONE cycle
      clear_log();
      send_req(32'h0F1E2D3C);
      run_to(401);
      check("t5_done_sent", flag_sent32, 1);
      send_req(32'hCAFEF00D);
      check("t5_tx_c402", uart_tx, 0);
      run_to(806);
      decode(401, word, ok);
      check("t5_word1", word, 32'hCAFEF00D);
      check("t5_frame1", ok, 1);
      check("t5_nsent", sent_at.size(), 2);
      check("t5_sent1", sent_at[1], 802);
      check("t5_ovr", overrun, 0);
      check("t5_busy_end", busy, 0);

      // 6: reset asserted during byte 2 start bit (cycles 201..210)
      clear_log();
      send_req(32'h89ABCDEF);
      run_to(205);
      check("t6_tx_pre", uart_tx, 0);
      rst_n = 1'b0;
      #1;
      check("t6_tx_async", uart_tx, 1);
      check("t6_busy_rst", busy, 0);
      repeat (3) step();
      rst_n = 1'b1;
      repeat (500) step();
      check("t6_nsent", sent_at.size(), 0);
      check("t6_busy_after", busy, 0);
      check("t6_tx_after", uart_tx, 1);

      clear_log();
      send_req(32'h13579BDF);
      run_to(405);
      decode(0, word, ok);
      check("t6_word", word, 32'h13579BDF);
      check("t6_frame", ok, 1);
      check("t6_nsent2", sent_at.size(), 1);
      check("t6_sent_cyc", sent_at[0], 401);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
